roll_display_driver: RTL and testbench

//  Sits downstream of DiceRoller and consumes its 8-bit rolled_number.
//  - Converts the value to 3 BCD digits with a sequential double-dabble engine, one shift per clock.
//  - Time-multiplexes the digits onto a common-anode 3-digit 7-segment display.
//  - Value 0 (no roll yet) is shown as "---".

---
 rtl/roll_display_driver.sv | 154 +++++++++++++++
 tb/tb_roll_display_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/roll_display_driver.sv
// Converts a DiceRoller result to BCD with a one-shift-per-clock double-dabble engine
// and scans it onto a common-anode 3-digit 7-segment display ("---" until a non-zero roll).
module roll_display_driver #(
  parameter int REFRESH_DIV   = 1000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [7:0]  rolled_number,
  output logic        busy,
  output logic        done,
  output logic [11:0] bcd_value,
  output logic [6:0]  seg_n,
  output logic [2:0]  an_n
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  bin_q, bin_d;
  logic [7:0]  cap_q, cap_d;
  logic [7:0]  stored_q, stored_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] bcd_q, bcd_d;
  logic [3:0]  iter_q, iter_d;
  logic        done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic [11:0] accAdj;

  function automatic logic [3:0] dabble(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  function automatic logic [6:0] segOf(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_DASH;
    endcase
  endfunction

  // A load in any state (re)starts a conversion; the newest value always wins.
  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    cap_d    = cap_q;
    stored_d = stored_q;
    acc_d    = acc_q;
    bcd_d    = bcd_q;
    iter_d   = iter_q;
    done_d   = 1'b0;
    accAdj   = {dabble(acc_q[11:8]), dabble(acc_q[7:4]), dabble(acc_q[3:0])};
    if (load) begin
      bin_d   = rolled_number;
      cap_d   = rolled_number;
      acc_d   = '0;
      iter_d  = '0;
      state_d = CONV;
    end else begin
      case (state_q)
        CONV: begin
          {acc_d, bin_d} = {accAdj, bin_q} << 1;
          iter_d = iter_q + 4'd1;
          if (iter_q == 4'd7) state_d = DONE;
        end
        DONE: begin
          bcd_d    = acc_q;
          stored_d = cap_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Segments are computed from the next-cycle digit index and result, so an_n and seg_n
  // always change on the same edge and a new result appears exactly when done fires.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    case (idx_d)
      2'd1:    an_d = 3'b101;
      2'd2:    an_d = 3'b011;
      default: an_d = 3'b110;
    endcase
    seg_d = SEG_DASH;
    if (stored_d != 8'd0) begin
      case (idx_d)
        2'd0: seg_d = segOf(bcd_d[3:0]);
        2'd1: seg_d = (BLANK_LEADING != 0 && bcd_d[11:8] == 4'd0 && bcd_d[7:4] == 4'd0)
                      ? SEG_BLANK : segOf(bcd_d[7:4]);
        2'd2: seg_d = (BLANK_LEADING != 0 && bcd_d[11:8] == 4'd0)
                      ? SEG_BLANK : segOf(bcd_d[11:8]);
        default: seg_d = SEG_DASH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      cap_q    <= '0;
      stored_q <= '0;
      acc_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= 3'b110;
      seg_q    <= SEG_DASH;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      cap_q    <= cap_d;
      stored_q <= stored_d;
      acc_q    <= acc_d;
      bcd_q    <= bcd_d;
      iter_q   <= iter_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign bcd_value = bcd_q;
  assign seg_n     = seg_q;
  assign an_n      = an_q;

endmodule

// File: tb/tb_roll_display_driver.sv
// Directed bench for roll_display_driver: two instances with a fast 4-clock scan,
// one blanking leading zeros and one showing all digits.
module tb_roll_display_driver;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load;
  logic [7:0]  rolledNumber;
  logic        busyA, doneA, busyB, doneB;
  logic [11:0] bcdA, bcdB;
  logic [6:0]  segA, segB;
  logic [2:0]  anA, anB;

  int nChecks = 0;
  int nFails  = 0;
  logic [6:0] obs [3];
  bit scanErr;

  always #5 clk = ~clk;

  roll_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(1)) dutA (
    .clk(clk), .reset_n(reset_n), .load(load), .rolled_number(rolledNumber),
    .busy(busyA), .done(doneA), .bcd_value(bcdA), .seg_n(segA), .an_n(anA));

  roll_display_driver #(.REFRESH_DIV(4), .BLANK_LEADING(0)) dutB (
    .clk(clk), .reset_n(reset_n), .load(load), .rolled_number(rolledNumber),
    .busy(busyB), .done(doneB), .bcd_value(bcdB), .seg_n(segB), .an_n(anB));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses load with value v and counts edges until done; cycles = -1 if it never comes.
  task automatic loadAndWait(input logic [7:0] v, output int cycles);
    load = 1'b1;
    rolledNumber = v;
    tick();
    load = 1'b0;
    cycles = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (doneA) begin
        cycles = k;
        return;
      end
    end
  endtask

  // Records the segment pattern seen in each scan slot over a full scan period.
  task automatic captureScan(input bit useB);
    bit seen [3];
    int slot;
    logic [2:0] a;
    logic [6:0] s;
    scanErr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen[i] = 1'b0;
      obs[i]  = 'x;
    end
    for (int c = 0; c < 12; c++) begin
      tick();
      a = useB ? anB : anA;
      s = useB ? segB : segA;
      case (a)
        3'b110:  slot = 0;
        3'b101:  slot = 1;
        3'b011:  slot = 2;
        default: slot = -1;
      endcase
      if (slot < 0) scanErr = 1'b1;
      else begin
        if (seen[slot] && obs[slot] !== s) scanErr = 1'b1;
        obs[slot]  = s;
        seen[slot] = 1'b1;
      end
    end
    for (int i = 0; i < 3; i++) if (!seen[i]) scanErr = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    load = 1'b0;
    rolledNumber = 8'd0;
    tick();
    tick();
    nChecks++; if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", busyA); end
    nChecks++; if (doneA !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done: got %b expected 0", doneA); end
    nChecks++; if (bcdA !== 12'h000) begin nFails++; $display("[TB] FAIL reset_bcd: got %h expected 000", bcdA); end
    nChecks++; if (anA !== 3'b110) begin nFails++; $display("[TB] FAIL reset_an: got %b expected 110", anA); end
    nChecks++; if (segA !== DASH) begin nFails++; $display("[TB] FAIL reset_seg: got %b expected %b", segA, DASH); end
    reset_n = 1'b1;
  endtask

  task automatic test_scan_order();
    logic [2:0] expAn;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      case ((k / 4) % 3)
        1:       expAn = 3'b101;
        2:       expAn = 3'b011;
        default: expAn = 3'b110;
      endcase
      nChecks++; if (anA !== expAn) begin nFails++; $display("[TB] FAIL scan_an[%0d]: got %b expected %b", k, anA, expAn); end
      nChecks++; if (segA !== DASH) begin nFails++; $display("[TB] FAIL scan_seg[%0d]: got %b expected %b", k, segA, DASH); end
    end
  endtask

  task automatic test_load_20();
    int cyc;
    loadAndWait(8'd20, cyc);
    nChecks++; if (cyc !== 9) begin nFails++; $display("[TB] FAIL lat_20: got %0d expected 9", cyc); end
    nChecks++; if (bcdA !== 12'h020) begin nFails++; $display("[TB] FAIL bcd_20: got %h expected 020", bcdA); end
    nChecks++; if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL busy_20: got %b expected 0", busyA); end
    tick();
    nChecks++; if (doneA !== 1'b0) begin nFails++; $display("[TB] FAIL done_width_20: got %b expected 0", doneA); end
    captureScan(1'b0);
    nChecks++; if (scanErr) begin nFails++; $display("[TB] FAIL scan_pair_20: got error expected none"); end
    nChecks++; if (obs[0] !== 7'b1000000) begin nFails++; $display("[TB] FAIL ones_20: got %b expected 1000000", obs[0]); end
    nChecks++; if (obs[1] !== 7'b0100100) begin nFails++; $display("[TB] FAIL tens_20: got %b expected 0100100", obs[1]); end
    nChecks++; if (obs[2] !== BLANK) begin nFails++; $display("[TB] FAIL hund_20: got %b expected 1111111", obs[2]); end
  endtask

  task automatic test_load_255();
    int cyc;
    loadAndWait(8'd255, cyc);
    nChecks++; if (cyc !== 9) begin nFails++; $display("[TB] FAIL lat_255: got %0d expected 9", cyc); end
    nChecks++; if (bcdA !== 12'h255) begin nFails++; $display("[TB] FAIL bcd_255: got %h expected 255", bcdA); end
    captureScan(1'b0);
    nChecks++; if (obs[0] !== 7'b0010010) begin nFails++; $display("[TB] FAIL ones_255: got %b expected 0010010", obs[0]); end
    nChecks++; if (obs[1] !== 7'b0010010) begin nFails++; $display("[TB] FAIL tens_255: got %b expected 0010010", obs[1]); end
    nChecks++; if (obs[2] !== 7'b0100100) begin nFails++; $display("[TB] FAIL hund_255: got %b expected 0100100", obs[2]); end
  endtask

  task automatic test_no_blank();
    int cyc;
    loadAndWait(8'd7, cyc);
    nChecks++; if (cyc !== 9) begin nFails++; $display("[TB] FAIL lat_7: got %0d expected 9", cyc); end
    nChecks++; if (bcdB !== 12'h007) begin nFails++; $display("[TB] FAIL bcd_7: got %h expected 007", bcdB); end
    captureScan(1'b1);
    nChecks++; if (scanErr) begin nFails++; $display("[TB] FAIL scan_pair_7: got error expected none"); end
    nChecks++; if (obs[0] !== 7'b1111000) begin nFails++; $display("[TB] FAIL ones_7: got %b expected 1111000", obs[0]); end
    nChecks++; if (obs[1] !== 7'b1000000) begin nFails++; $display("[TB] FAIL tens_7_noblank: got %b expected 1000000", obs[1]); end
    nChecks++; if (obs[2] !== 7'b1000000) begin nFails++; $display("[TB] FAIL hund_7_noblank: got %b expected 1000000", obs[2]); end
    captureScan(1'b0);
    nChecks++; if (obs[1] !== BLANK) begin nFails++; $display("[TB] FAIL tens_7_blank: got %b expected 1111111", obs[1]); end
    nChecks++; if (obs[2] !== BLANK) begin nFails++; $display("[TB] FAIL hund_7_blank: got %b expected 1111111", obs[2]); end
  endtask

  task automatic test_zero();
    int cyc;
    loadAndWait(8'd0, cyc);
    nChecks++; if (cyc !== 9) begin nFails++; $display("[TB] FAIL lat_0: got %0d expected 9", cyc); end
    nChecks++; if (bcdA !== 12'h000) begin nFails++; $display("[TB] FAIL bcd_0: got %h expected 000", bcdA); end
    captureScan(1'b1);
    nChecks++; if (obs[0] !== DASH || obs[1] !== DASH || obs[2] !== DASH) begin
      nFails++; $display("[TB] FAIL dash_0: got %b %b %b expected all 0111111", obs[2], obs[1], obs[0]);
    end
  endtask

  task automatic test_restart();
    int cyc;
    load = 1'b1;
    rolledNumber = 8'd6;
    tick();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      nChecks++; if (doneA !== 1'b0 || busyA !== 1'b1) begin nFails++; $display("[TB] FAIL restart_pre[%0d]: got done=%b busy=%b expected done=0 busy=1", k, doneA, busyA); end
    end
    nChecks++; if (bcdA !== 12'h000) begin nFails++; $display("[TB] FAIL restart_hold: got %h expected 000", bcdA); end
    loadAndWait(8'd18, cyc);
    nChecks++; if (cyc !== 9) begin nFails++; $display("[TB] FAIL lat_restart: got %0d expected 9", cyc); end
    nChecks++; if (bcdA !== 12'h018) begin nFails++; $display("[TB] FAIL bcd_18: got %h expected 018", bcdA); end
    captureScan(1'b0);
    nChecks++; if (obs[0] !== 7'b0000000) begin nFails++; $display("[TB] FAIL ones_18: got %b expected 0000000", obs[0]); end
    nChecks++; if (obs[1] !== 7'b1111001) begin nFails++; $display("[TB] FAIL tens_18: got %b expected 1111001", obs[1]); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    loadAndWait(8'd5, cyc);
    nChecks++; if (cyc !== 9) begin nFails++; $display("[TB] FAIL lat_5: got %0d expected 9", cyc); end
    loadAndWait(8'd42, cyc);
    nChecks++; if (cyc !== 9) begin nFails++; $display("[TB] FAIL lat_42: got %0d expected 9", cyc); end
    nChecks++; if (bcdA !== 12'h042) begin nFails++; $display("[TB] FAIL bcd_42: got %h expected 042", bcdA); end
    captureScan(1'b0);
    nChecks++; if (obs[0] !== 7'b0100100) begin nFails++; $display("[TB] FAIL ones_42: got %b expected 0100100", obs[0]); end
    nChecks++; if (obs[1] !== 7'b0011001) begin nFails++; $display("[TB] FAIL tens_42: got %b expected 0011001", obs[1]); end
  endtask

  task automatic test_reset_mid_conv();
    bit sawDone;
    load = 1'b1;
    rolledNumber = 8'd100;
    tick();
    load = 1'b0;
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    nChecks++; if (busyA !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", busyA); end
    nChecks++; if (anA !== 3'b110) begin nFails++; $display("[TB] FAIL rst_mid_an: got %b expected 110", anA); end
    nChecks++; if (segA !== DASH) begin nFails++; $display("[TB] FAIL rst_mid_seg: got %b expected %b", segA, DASH); end
    nChecks++; if (bcdA !== 12'h000) begin nFails++; $display("[TB] FAIL rst_mid_bcd: got %h expected 000", bcdA); end
    tick();
    reset_n = 1'b1;
    sawDone = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (doneA || busyA) sawDone = 1'b1;
    end
    nChecks++; if (sawDone) begin nFails++; $display("[TB] FAIL rst_mid_nodone: got activity expected none"); end
  endtask

  initial begin
    test_reset();
    test_scan_order();
    test_load_20();
    test_load_255();
    test_no_blank();
    test_zero();
    test_restart();
    test_back_to_back();
    test_reset_mid_conv();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
